network_perf_counter_bank: RTL

Single-clock bank of event/byte performance counters for many network ports, with a 64-bit management read interface. It is the parametrised successor to the per-interface counter readout: any number of ports × counters, atomic per-port snapshot, and read-and-clear. It sits in the management clock domain behind the management bus decoder. All increment sources are already synchronised into `clk_mgmt` upstream.

---
 rtl/perf_counter_pkg.sv | 28 ++
 rtl/perf_counter_cell.sv | 61 ++++++
 rtl/network_perf_counter_bank.sv | 134 +++++++++++++
 3 files changed

// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: shared definitions for the network performance counter bank.
//   - management read address field layout (port, shadow select, reserved, index)
//   - architectural limits on ports and counters per port
//   - decoded read request struct used by the top-level decode
package perf_counter_pkg;

  // rd_addr layout: [15:8] port, [7] shadow, [6] reserved, [5:0] counter index
  localparam int ADDR_PORT_LSB   = 8;
  localparam int ADDR_PORT_W     = 8;
  localparam int ADDR_SHADOW_BIT = 7;
  localparam int ADDR_RSVD_BIT   = 6;
  localparam int ADDR_IDX_LSB    = 0;
  localparam int ADDR_IDX_W      = 6;

  localparam int MAX_PORTS    = 128;
  localparam int MAX_COUNTERS = 64;

  localparam int RD_DATA_W = 64;
  localparam int RD_STAGES = 2;

  typedef struct packed {
    logic [ADDR_PORT_W-1:0] port;
    logic                   shadow;
    logic [ADDR_IDX_W-1:0]  index;
    logic                   clear;
  } perf_rd_req_t;

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one live performance counter plus its snapshot shadow.
//   clk_mgmt  - block clock
//   rst       - synchronous active-high reset, clears both registers
//   inc_i     - per-cycle increment amount (0 = no event)
//   clear_i   - read-and-clear: next value becomes this cycle's inc_i
//   snap_i    - capture the pre-increment live value into the shadow
//   live_o    - current live counter value
//   shadow_o  - current shadow value
// Build option: PERF_COUNTER_SATURATE_EN defined -> counter sticks at all-ones
// on overflow; otherwise it wraps.
module perf_counter_cell
  import perf_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 48,
  parameter int INC_WIDTH     = 16
) (
  input  logic                     clk_mgmt,
  input  logic                     rst,
  input  logic [INC_WIDTH-1:0]     inc_i,
  input  logic                     clear_i,
  input  logic                     snap_i,
  output logic [COUNTER_WIDTH-1:0] live_o,
  output logic [COUNTER_WIDTH-1:0] shadow_o
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] shd_q;
  logic [COUNTER_WIDTH-1:0] inc_ext;

  assign inc_ext = COUNTER_WIDTH'(inc_i);

`ifdef PERF_COUNTER_SATURATE_EN
  logic [COUNTER_WIDTH:0] sum;
  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, inc_ext};
    cnt_d = sum[COUNTER_WIDTH] ? '1 : sum[COUNTER_WIDTH-1:0];
    // Clearing restarts from this cycle's events; inc fits, so no saturation.
    if (clear_i) cnt_d = inc_ext;
  end
`else
  always_comb begin
    cnt_d = cnt_q + inc_ext;
    if (clear_i) cnt_d = inc_ext;
  end
`endif

  always_ff @(posedge clk_mgmt) begin
    if (rst) begin
      cnt_q <= '0;
      shd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      // Pre-increment, pre-clear value, so a same-cycle read-clear is not lost.
      if (snap_i) shd_q <= cnt_q;
    end
  end

  assign live_o   = cnt_q;
  assign shadow_o = shd_q;

endmodule

// File: rtl/network_perf_counter_bank.sv
// network_perf_counter_bank: NUM_PORTS x NUM_COUNTERS event/byte counters with
// per-port atomic snapshot and a 2-stage pipelined 64-bit management read.
//   clk_mgmt   - single block clock
//   rst        - synchronous active-high reset
//   inc_amount - flat increments, counter (p,c) at slice p*NUM_COUNTERS+c
//   snap_en    - snapshot every counter of snap_port into its shadow
//   snap_port  - port to snapshot (out-of-range ignored)
//   rd_en      - read request, one per cycle accepted
//   rd_clear   - with rd_en on a live address: clear after reading
//   rd_addr    - [15:8] port, [7] shadow, [6] reserved (0), [5:0] index
//   rd_valid   - read result pulse, 2 cycles after rd_en
//   rd_data    - zero-extended counter value, holds between results
//   rd_err     - with rd_valid: address out of range (rd_data = 0)
// Build option: PERF_COUNTER_SATURATE_EN selects saturating counters (see
// perf_counter_cell); default is wrapping.
module network_perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int NUM_PORTS     = 8,
  parameter int NUM_COUNTERS  = 8,
  parameter int COUNTER_WIDTH = 48,
  parameter int INC_WIDTH     = 16
) (
  input  logic                                     clk_mgmt,
  input  logic                                     rst,
  input  logic [NUM_PORTS*NUM_COUNTERS*INC_WIDTH-1:0] inc_amount,
  input  logic                                     snap_en,
  input  logic [6:0]                               snap_port,
  input  logic                                     rd_en,
  input  logic                                     rd_clear,
  input  logic [15:0]                              rd_addr,
  output logic                                     rd_valid,
  output logic [RD_DATA_W-1:0]                     rd_data,
  output logic                                     rd_err
);

  typedef logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] row_t;

  row_t [NUM_PORTS-1:0]                   live, shadow;
  logic [NUM_PORTS-1:0]                   snap_vec;
  logic [NUM_PORTS-1:0][NUM_COUNTERS-1:0] clr_vec;

  perf_rd_req_t req;
  logic         req_err;

  // ---------------- decode ----------------
  always_comb begin
    req.port   = rd_addr[ADDR_PORT_LSB +: ADDR_PORT_W];
    req.shadow = rd_addr[ADDR_SHADOW_BIT];
    req.index  = rd_addr[ADDR_IDX_LSB +: ADDR_IDX_W];
    req.clear  = rd_clear;
    req_err    = (int'(req.port) >= NUM_PORTS) || (int'(req.index) >= NUM_COUNTERS) ||
                 rd_addr[ADDR_RSVD_BIT];
  end

  // ---------------- counter array ----------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign snap_vec[p] = snap_en && (int'(snap_port) == p);
    for (genvar c = 0; c < NUM_COUNTERS; c++) begin : g_cnt
      // Only a valid live address clears; shadow and error reads are side-effect free.
      assign clr_vec[p][c] = rd_en && req.clear && !req_err && !req.shadow &&
                             (int'(req.port) == p) && (int'(req.index) == c);
      perf_counter_cell #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .INC_WIDTH     (INC_WIDTH)
      ) u_cell (
        .clk_mgmt (clk_mgmt),
        .rst      (rst),
        .inc_i    (inc_amount[(p*NUM_COUNTERS+c)*INC_WIDTH +: INC_WIDTH]),
        .clear_i  (clr_vec[p][c]),
        .snap_i   (snap_vec[p]),
        .live_o   (live[p][c]),
        .shadow_o (shadow[p][c])
      );
    end
  end

  // ---------------- stage 1: port row select ----------------
  logic [RD_STAGES:1]    vld_pipe_q;
  row_t                  row_d, s1_row_q;
  logic [ADDR_IDX_W-1:0] s1_idx_q;
  logic                  s1_err_q;

  always_comb begin
    row_d = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (int'(req.port) == p) row_d = req.shadow ? shadow[p] : live[p];
  end

  always_ff @(posedge clk_mgmt) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_row_q   <= '0;
      s1_idx_q   <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[RD_STAGES-1:1], rd_en};
      if (rd_en) begin
        s1_row_q <= row_d;
        s1_idx_q <= req.index;
        s1_err_q <= req_err;
      end
    end
  end

  // ---------------- stage 2: counter mux, zero-extend, error ----------------
  logic [COUNTER_WIDTH-1:0] sel_d;
  logic [RD_DATA_W-1:0]     data_d, rd_data_q;
  logic                     rd_err_q;

  always_comb begin
    sel_d = '0;
    for (int c = 0; c < NUM_COUNTERS; c++)
      if (int'(s1_idx_q) == c) sel_d = s1_row_q[c];
    data_d = s1_err_q ? '0 : RD_DATA_W'(sel_d);
  end

  always_ff @(posedge clk_mgmt) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else if (vld_pipe_q[1]) begin
      rd_data_q <= data_d;
      rd_err_q  <= s1_err_q;
    end
  end

  // A result sitting in the output stage while rst is high is suppressed too,
  // so a reset drops every read still in flight.
  assign rd_valid = vld_pipe_q[RD_STAGES] && !rst;
  assign rd_err   = rd_valid && rd_err_q;
  assign rd_data  = rd_data_q;

endmodule
